prefix_gate_pipe: RTL and testbench

//  Parametrised successor to the fixed 4-input cascaded AND chain. Computes all prefix

---
 rtl/prefix_gate_pipe.sv | 142 ++++++++++++++
 tb/tb_prefix_gate_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_gate_pipe.sv
// prefix_gate_pipe
//   Two-stage valid/ready pipeline that computes every prefix reduction of an
//   N-bit operand vector: out_prefix[k] = op(in_data[0..k+1]). The operation is
//   chosen per beat and travels with its data. A saturating counter tracks
//   accepted output beats whose full reduction (out_all) is 1.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready producer handshake; in_data (N bits, bit 0 first), in_op
//                     00 AND, 01 OR, 10 XOR, 11 NAND (inverted AND prefix)
//   out_valid/out_ready consumer handshake; out_prefix (N-1 bits), out_all
//   hit_clr           synchronous clear of hit_cnt, wins over an increment
//   hit_cnt           saturating count of accepted beats with out_all == 1
module prefix_gate_pipe #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-2:0]     out_prefix,
  output logic             out_all,
  input  logic             hit_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_data_q, s1_data_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [N-2:0]     out_prefix_q, out_prefix_d;
  logic             out_all_q, out_all_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic s2_ready, s1_fire, s2_fire, out_accept;

  logic [N-2:0] pre_and, pre_or, pre_xor, prefix_c;
  logic         acc_and, acc_or, acc_xor;

  assign s2_ready   = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_ready;
  assign s1_fire    = in_valid && in_ready;
  assign s2_fire    = s1_valid_q && s2_ready;
  assign out_accept = out_valid_q && out_ready;

  // Running accumulators give all prefixes in one pass; NAND is the inverted
  // AND prefix rather than a chained NAND.
  always_comb begin
    pre_and  = '0;
    pre_or   = '0;
    pre_xor  = '0;
    prefix_c = '0;
    acc_and  = s1_data_q[0];
    acc_or   = s1_data_q[0];
    acc_xor  = s1_data_q[0];
    for (int k = 0; k < N - 1; k++) begin
      acc_and    = acc_and & s1_data_q[k+1];
      acc_or     = acc_or  | s1_data_q[k+1];
      acc_xor    = acc_xor ^ s1_data_q[k+1];
      pre_and[k] = acc_and;
      pre_or[k]  = acc_or;
      pre_xor[k] = acc_xor;
    end
    case (s1_op_q)
      OP_AND:  prefix_c = pre_and;
      OP_OR:   prefix_c = pre_or;
      OP_XOR:  prefix_c = pre_xor;
      OP_NAND: prefix_c = ~pre_and;
      default: prefix_c = pre_and;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_op_d      = s1_op_q;
    out_valid_d  = out_valid_q;
    out_prefix_d = out_prefix_q;
    out_all_d    = out_all_q;
    hit_cnt_d    = hit_cnt_q;

    // Operands are only sampled on a handshake so idle X on the bus never
    // reaches the registers.
    if (s1_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_op_d    = in_op;
    end else if (s2_fire) begin
      s1_valid_d = 1'b0;
    end

    if (s2_fire) begin
      out_valid_d  = 1'b1;
      out_prefix_d = prefix_c;
      out_all_d    = prefix_c[N-2];
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end

    if (hit_clr) begin
      hit_cnt_d = '0;
    end else if (out_accept && out_all_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_op_q      <= '0;
      out_valid_q  <= 1'b0;
      out_prefix_q <= '0;
      out_all_q    <= 1'b0;
      hit_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_op_q      <= s1_op_d;
      out_valid_q  <= out_valid_d;
      out_prefix_q <= out_prefix_d;
      out_all_q    <= out_all_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_prefix = out_prefix_q;
  assign out_all    = out_all_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_prefix_gate_pipe.sv
module tb_prefix_gate_pipe;
  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-2:0]     out_prefix;
  logic             out_all;
  logic             hit_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;

  int n_checks = 0;
  int n_bad    = 0;

  // model state: beats accepted but not yet delivered, and expected hit count
  logic [N-2:0] exp_q[$];
  int           model_cnt = 0;

  // observations from the most recent step
  bit           last_acc_in, last_acc_out, last_empty;
  logic         last_obs_valid, last_obs_ready, last_exp_ready;
  logic [N-2:0] last_obs_p, last_exp_p;
  logic         last_obs_a;

  prefix_gate_pipe #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_prefix(out_prefix),
    .out_all(out_all), .hit_clr(hit_clr), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Reference: count ones in the first k+2 bits and decide from that count.
  function automatic logic [N-2:0] ref_prefix(input logic [N-1:0] d, input logic [1:0] op);
    logic [N-2:0] r;
    int ones;
    r = '0;
    for (int k = 0; k < N - 1; k++) begin
      ones = 0;
      for (int j = 0; j <= k + 1; j++) ones += int'(d[j]);
      case (op)
        2'd0: r[k] = (ones == k + 2);
        2'd1: r[k] = (ones != 0);
        2'd2: r[k] = ones[0];
        default: r[k] = (ones != k + 2);
      endcase
    end
    return r;
  endfunction

  // Drive one cycle from just after a negedge, record what happened, update
  // the model, and return at the following negedge.
  task automatic step(input bit iv, input logic [N-1:0] d, input logic [1:0] op,
                      input bit ordy, input bit clr);
    in_valid  = iv;
    in_data   = d;
    in_op     = op;
    out_ready = ordy;
    hit_clr   = clr;
    #1;
    last_exp_ready = !(exp_q.size() == 2 && !ordy);
    last_obs_ready = in_ready;
    last_obs_valid = out_valid;
    last_obs_p     = out_prefix;
    last_obs_a     = out_all;
    last_acc_in    = iv && in_ready;
    last_acc_out   = out_valid && ordy;
    last_empty     = 1'b0;
    last_exp_p     = '0;
    if (last_acc_out) begin
      if (exp_q.size() == 0) last_empty = 1'b1;
      else last_exp_p = exp_q.pop_front();
    end
    if (last_acc_in) exp_q.push_back(ref_prefix(d, op));
    if (clr) model_cnt = 0;
    else if (last_acc_out && !last_empty && last_exp_p[N-2] && model_cnt < CMAX) model_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    hit_clr = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_prefix !== '0 || out_all !== 1'b0 || hit_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b prefix=%b all=%b cnt=%0d want 0/000/0/0",
               out_valid, out_prefix, out_all, hit_cnt);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_and_ones();
    step(1, 4'b1111, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    n_checks++;
    if (last_obs_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL and_ones_early: out_valid got %b want 0 one cycle after accept", last_obs_valid);
    end
    step(0, 4'b0000, 2'b00, 1, 0);
    n_checks++;
    if (last_obs_valid !== 1'b1 || last_obs_p !== 3'b111 || last_obs_a !== 1'b1) begin
      n_bad++;
      $display("FAIL and_ones: got valid=%b prefix=%b all=%b want 1/111/1",
               last_obs_valid, last_obs_p, last_obs_a);
    end
    n_checks++;
    if (hit_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL and_ones_hit: got %0d want 1", hit_cnt);
    end
  endtask

  task automatic test_and_partial();
    step(1, 4'b1011, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    n_checks++;
    if (last_obs_valid !== 1'b1 || last_obs_p !== 3'b001 || last_obs_a !== 1'b0) begin
      n_bad++;
      $display("FAIL and_1011: got valid=%b prefix=%b all=%b want 1/001/0",
               last_obs_valid, last_obs_p, last_obs_a);
    end
    n_checks++;
    if (hit_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL and_1011_hit: got %0d want 1", hit_cnt);
    end
  endtask

  task automatic test_op_sweep();
    logic [N-2:0] want[3];
    logic [1:0]   ops[3];
    int got;
    want = '{3'b111, 3'b001, 3'b111};
    ops  = '{2'b01, 2'b10, 2'b11};
    got = 0;
    for (int i = 0; i < 8 && got < 3; i++) begin
      step(i < 3, 4'b0110, ops[i < 3 ? i : 0], 1, 0);
      if (last_acc_out) begin
        n_checks++;
        if (last_obs_p !== want[got] || last_obs_a !== want[got][N-2]) begin
          n_bad++;
          $display("FAIL op_sweep[%0d]: got prefix=%b all=%b want %b", got, last_obs_p,
                   last_obs_a, want[got]);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 3 || hit_cnt !== 2'd3) begin
      n_bad++;
      $display("FAIL op_sweep_count: got beats=%0d cnt=%0d want 3/3", got, hit_cnt);
    end
  endtask

  task automatic test_random();
    int i;
    for (int c = 0; c < 300; c++) begin
      i = c;
      step(c < 260 && ($urandom % 4 != 0), N'($urandom), 2'($urandom),
           ($urandom % 3 != 0) || c >= 260, ($urandom % 16 == 0));
      n_checks++;
      if (last_obs_ready !== last_exp_ready) begin
        n_bad++;
        $display("FAIL rand_in_ready @%0d: got %b want %b", i, last_obs_ready, last_exp_ready);
      end
      if (last_acc_out) begin
        n_checks++;
        if (last_empty || last_obs_p !== last_exp_p || last_obs_a !== last_exp_p[N-2]) begin
          n_bad++;
          $display("FAIL rand_beat @%0d: got prefix=%b all=%b want %b (spurious=%0d)",
                   i, last_obs_p, last_obs_a, last_exp_p, last_empty);
        end
      end
      n_checks++;
      if (int'(hit_cnt) != model_cnt) begin
        n_bad++;
        $display("FAIL rand_hit_cnt @%0d: got %0d want %0d", i, hit_cnt, model_cnt);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: %0d beats never delivered, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] bd[5];
    logic [1:0]   bo[5];
    logic [N-2:0] held;
    bit           stalled;
    int sent, got;
    for (int i = 0; i < 5; i++) begin
      bd[i] = N'($urandom);
      bo[i] = 2'($urandom);
    end
    sent = 0;
    got = 0;
    stalled = 0;
    held = '0;
    for (int c = 0; c < 30 && (sent < 5 || exp_q.size() > 0); c++) begin
      step(sent < 5, bd[sent < 5 ? sent : 0], bo[sent < 5 ? sent : 0], c >= 4, 0);
      n_checks++;
      if (last_obs_ready !== last_exp_ready) begin
        n_bad++;
        $display("FAIL bp_in_ready @%0d: got %b want %b", c, last_obs_ready, last_exp_ready);
      end
      if (stalled) begin
        n_checks++;
        if (last_obs_valid !== 1'b1 || last_obs_p !== held) begin
          n_bad++;
          $display("FAIL bp_stable @%0d: got valid=%b prefix=%b want 1/%b", c,
                   last_obs_valid, last_obs_p, held);
        end
      end
      stalled = last_obs_valid && (c < 4);
      held = last_obs_p;
      if (last_acc_in) sent++;
      if (last_acc_out) begin
        n_checks++;
        if (last_empty || last_obs_p !== last_exp_p) begin
          n_bad++;
          $display("FAIL bp_beat[%0d]: got %b want %b", got, last_obs_p, last_exp_p);
        end
        got++;
      end
      if (c == 3) begin
        n_checks++;
        if (sent != 2) begin
          n_bad++;
          $display("FAIL bp_accepted_during_stall: got %0d want 2", sent);
        end
      end
    end
    n_checks++;
    if (got != 5 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_delivered: got %0d want 5", got);
    end
  endtask

  task automatic test_saturate();
    int k;
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 5, 4'b1111, 2'b00, 1, 0);
      if (last_acc_out) begin
        k++;
        n_checks++;
        if (int'(hit_cnt) != (k < CMAX ? k : CMAX)) begin
          n_bad++;
          $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, hit_cnt, (k < CMAX ? k : CMAX));
        end
      end
    end
    n_checks++;
    if (k != 5) begin
      n_bad++;
      $display("FAIL sat_beats: got %0d want 5", k);
    end
    step(1, 4'b1111, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 1);
    n_checks++;
    if (last_acc_out !== 1'b1 || last_obs_a !== 1'b1 || hit_cnt !== '0) begin
      n_bad++;
      $display("FAIL clr_vs_hit: got accept=%b all=%b cnt=%0d want 1/1/0",
               last_acc_out, last_obs_a, hit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    step(1, 4'b1111, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    step(0, 4'b0000, 2'b00, 1, 0);
    step(1, 4'b0101, 2'b01, 0, 0);
    step(1, 4'b0011, 2'b10, 0, 0);
    step(1, 4'b1001, 2'b11, 0, 0);
    n_checks++;
    if (last_obs_ready !== 1'b0 || last_obs_valid !== 1'b1 || hit_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_full: got ready=%b valid=%b cnt=%0d want 0/1/1",
               last_obs_ready, last_obs_valid, hit_cnt);
    end
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0 || hit_cnt !== '0 || out_prefix !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b cnt=%0d prefix=%b want 0/0/000",
               out_valid, hit_cnt, out_prefix);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'b1111, 2'b00, 1, 0);
    seen = 0;
    for (int i = 1; i <= 6 && seen == 0; i++) begin
      step(0, 4'b0000, 2'b00, 1, 0);
      if (last_obs_valid) seen = i;
    end
    n_checks++;
    if (seen != 2 || last_obs_p !== 3'b111 || hit_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_after: got latency=%0d prefix=%b cnt=%0d want 2/111/1",
               seen, last_obs_p, hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_and_ones();
    test_and_partial();
    test_op_sweep();
    test_random();
    test_back_pressure();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
